// File: rtl/core_ctrl.sv
// Pipeline sequencer: owns the core state, drives global stall and EXE bubble,
// and counts stalled RUN/MEMWAIT cycles.
module core_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dec_instr_i,
  input  logic [4:0]  exe_rd_ptr_i,
  input  logic        exe_mem_re_i,
  input  logic        imem_valid_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        halt_req_i,
  output logic [7:0]  core_state_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        err_o,
  output logic [31:0] stall_count_o
);

  localparam int unsigned BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [7:0] {
    BOOT    = 8'h01,
    RUN     = 8'h02,
    MEMWAIT = 8'h04,
    HALT    = 8'h08,
    ERROR   = 8'h10
  } state_t;

  state_t          state;
  logic [BW-1:0]   boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            err;
  logic [31:0]     stall_count;

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            use_rs1;
  logic            use_rs2;
  logic            hazard;
  logic            stall;
  logic            bubble;
  logic            unused;

  assign unused = ^{dec_instr_i[31:25], dec_instr_i[14:7]};

  always_comb begin
    opcode  = dec_instr_i[6:0];
    rs1     = dec_instr_i[19:15];
    rs2     = dec_instr_i[24:20];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = exe_mem_re_i && (exe_rd_ptr_i != 5'd0) &&
                  ((use_rs1 && (rs1 == exe_rd_ptr_i)) ||
                   (use_rs2 && (rs2 == exe_rd_ptr_i)));

  // RUN priority: outstanding memory miss, then halt, fetch gap, load-use.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    unique case (state)
      BOOT: bubble = 1'b1;
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          stall = 1'b1;
        end else if (halt_req_i || !imem_valid_i || hazard) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      MEMWAIT: stall = !mem_ack_i;
      HALT, ERROR: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      wait_cnt    <= '0;
      err         <= 1'b0;
      stall_count <= '0;
    end else begin
      if ((state == RUN || state == MEMWAIT) && stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;

      unique case (state)
        BOOT: begin
          if (boot_cnt == BW'(BOOT_CYCLES - 1))
            state <= RUN;
          else
            boot_cnt <= boot_cnt + BW'(1);
        end
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            state    <= MEMWAIT;
            wait_cnt <= WW'(1);
          end else if (halt_req_i) begin
            state <= HALT;
          end
        end
        // Ack beats timeout; a pending halt is picked up once back in RUN.
        MEMWAIT: begin
          if (mem_ack_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        HALT: begin
          if (!halt_req_i)
            state <= RUN;
        end
        ERROR: err <= 1'b1;
        default: begin
          state <= ERROR;
          err   <= 1'b1;
        end
      endcase
    end
  end

  assign core_state_o  = state;
  assign stall_o       = stall;
  assign bubble_o      = bubble;
  assign err_o         = err;
  assign stall_count_o = stall_count;

endmodule
